// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state/owner encodings and default widths for mem_port_arbiter
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arbState_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// rtl/mem_port_arbiter_arb_pick.sv - combinational winner selection between fetch and data ports
// ARB_ROUND_ROBIN_EN selects alternating priority under contention; otherwise data beats fetch.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   ifReq,
    input  logic   dReq,
    input  owner_t lastGrant,
    output owner_t winner
);

    always_comb begin
        winner = OWN_NONE;
`ifdef ARB_ROUND_ROBIN_EN
        if (ifReq && dReq) begin
            winner = (lastGrant == OWN_DATA) ? OWN_IF : OWN_DATA;
        end else if (dReq) begin
            winner = OWN_DATA;
        end else if (ifReq) begin
            winner = OWN_IF;
        end
`else
        if (dReq) begin
            winner = OWN_DATA;
        end else if (ifReq) begin
            winner = OWN_IF;
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    owner_t unusedLastGrant;
    assign unusedLastGrant = lastGrant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and data ports onto one single-ported memory
// Optional ARB_ROUND_ROBIN_EN builds a last-grant register for alternating contention priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifAck,
    output logic [DATA_W-1:0] ifRdata,
    output logic              ifStall,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic              dAck,
    output logic [DATA_W-1:0] dRdata,
    output logic              dStall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic              memReady,
    input  logic [DATA_W-1:0] memRdata,
    output logic              busy
);

    arbState_t state;
    owner_t    owner;
    owner_t    winner;
    owner_t    lastGrant;

    arb_pick uPick (
        .ifReq     (ifReq),
        .dReq      (dReq),
        .lastGrant (lastGrant),
        .winner    (winner)
    );

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lastGrant <= OWN_IF;
        end else if (state == ST_IDLE && winner != OWN_NONE) begin
            lastGrant <= winner;
        end
    end
`else
    assign lastGrant = OWN_IF;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= ST_IDLE;
            owner    <= OWN_NONE;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            ifAck    <= 1'b0;
            dAck     <= 1'b0;
            ifRdata  <= '0;
            dRdata   <= '0;
        end else begin
            ifAck <= 1'b0;
            dAck  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (winner != OWN_NONE) begin
                        owner  <= winner;
                        memReq <= 1'b1;
                        state  <= ST_BUSY;
                        if (winner == OWN_DATA) begin
                            memAddr  <= dAddr;
                            memWe    <= dWe;
                            memWdata <= dWdata;
                        end else begin
                            memAddr  <= ifAddr;
                            memWe    <= 1'b0;
                        end
                    end
                end
                // Request lines are ignored here: a dropped request still completes.
                ST_BUSY: begin
                    if (memReady) begin
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                        state  <= ST_RESP;
                        if (owner == OWN_DATA) begin
                            dAck <= 1'b1;
                            if (!memWe) begin
                                dRdata <= memRdata;
                            end
                        end else begin
                            ifAck   <= 1'b1;
                            ifRdata <= memRdata;
                        end
                    end
                end
                ST_RESP: begin
                    owner <= OWN_NONE;
                    state <= ST_IDLE;
                end
                default: begin
                    owner  <= OWN_NONE;
                    memReq <= 1'b0;
                    memWe  <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != ST_IDLE);
    assign ifStall = ifReq & ~ifAck;
    assign dStall  = dReq & ~dAck;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a latency-programmable memory
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        ifReq = 1'b0;
    logic [31:0] ifAddr = '0;
    logic        ifAck;
    logic [31:0] ifRdata;
    logic        ifStall;
    logic        dReq = 1'b0;
    logic        dWe = 1'b0;
    logic [31:0] dAddr = '0;
    logic [31:0] dWdata = '0;
    logic        dAck;
    logic [31:0] dRdata;
    logic        dStall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memReady = 1'b0;
    logic [31:0] memRdata = '0;
    logic        busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetN(resetN),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifAck(ifAck), .ifRdata(ifRdata), .ifStall(ifStall),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dAck(dAck), .dRdata(dRdata), .dStall(dStall),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memReady(memReady), .memRdata(memRdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isData;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        got;
    logic [31:0] mdl [0:255];
    int          memLat = 1;
    int          waitCnt = 0;
    int          total = 0;
    int          bad = 0;
    bit          firstIsData;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE0000 | 32'(a);
    endfunction

    // Memory model: answers memLat cycles after memReq first appears.
    always @(posedge clk) begin
        #1;
        if (memReq) begin
            if (waitCnt + 1 >= memLat) begin
                memReady = 1'b1;
                if (memWe) mdl[memAddr[7:0]] = memWdata;
                memRdata = mdl[memAddr[7:0]];
            end else begin
                memReady = 1'b0;
            end
            waitCnt++;
        end else begin
            memReady = 1'b0;
            memRdata = '0;
            waitCnt  = 0;
        end
    end

    // Ack monitor pops the scoreboard on every acknowledge.
    always @(posedge clk) begin
        #1;
        if (ifAck || dAck) begin
            chk("oneAckOnly", {63'b0, ifAck & dAck}, 64'd0);
            if (sbq.size() == 0) begin
                chk("spuriousAck", {62'b0, ifAck, dAck}, 64'd0);
            end else begin
                got = sbq.pop_front();
                chk("ackPort", {63'b0, dAck}, {63'b0, got.isData});
                if (got.isData) chk("dRdata", {32'b0, dRdata}, {32'b0, got.data});
                else            chk("ifRdata", {32'b0, ifRdata}, {32'b0, got.data});
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mdl[i] = pat(i);
        mdl[6] = 32'h00A00093;

        #1 resetN = 1'b0;
        #1;
        chk("rstMemReq", {63'b0, memReq}, 64'd0);
        chk("rstMemWe", {63'b0, memWe}, 64'd0);
        chk("rstMemAddr", {32'b0, memAddr}, 64'd0);
        chk("rstMemWdata", {32'b0, memWdata}, 64'd0);
        chk("rstAcks", {62'b0, ifAck, dAck}, 64'd0);
        chk("rstIfRdata", {32'b0, ifRdata}, 64'd0);
        chk("rstDRdata", {32'b0, dRdata}, 64'd0);
        chk("rstBusy", {63'b0, busy}, 64'd0);
        tick();
        tick();
        resetN = 1'b1;
        tick();

        // Fetch read, immediate memory.
        memLat = 1;
        ifReq = 1'b1; ifAddr = 32'h06;
        sbq.push_back('{isData: 1'b0, data: 32'h00A00093});
        #1;
        chk("t1Stall0", {63'b0, ifStall}, 64'd1);
        chk("t1Busy0", {63'b0, busy}, 64'd0);
        tick();
        chk("t1MemReq1", {63'b0, memReq}, 64'd1);
        chk("t1MemWe1", {63'b0, memWe}, 64'd0);
        chk("t1MemAddr1", {32'b0, memAddr}, 64'h06);
        chk("t1Stall1", {63'b0, ifStall}, 64'd1);
        tick();
        chk("t1Ack2", {63'b0, ifAck}, 64'd1);
        chk("t1Stall2", {63'b0, ifStall}, 64'd0);
        chk("t1MemReq2", {63'b0, memReq}, 64'd0);
        ifReq = 1'b0;
        tick();
        chk("t1Idle3", {63'b0, busy}, 64'd0);

        // Data write, latency 3.
        memLat = 3;
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h0B; dWdata = 32'h5;
        sbq.push_back('{isData: 1'b1, data: 32'h0});
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("t2MemReq", {63'b0, memReq}, {63'b0, c < 4});
            chk("t2MemWe", {63'b0, memWe}, {63'b0, c < 4});
            chk("t2MemAddr", {32'b0, memAddr}, 64'h0B);
            chk("t2MemWdata", {32'b0, memWdata}, 64'h5);
            chk("t2DAck", {63'b0, dAck}, {63'b0, c == 4});
        end
        dReq = 1'b0; dWe = 1'b0;
        tick();

        // Simultaneous fetch and data read, immediate memory.
        memLat = 1;
`ifdef ARB_ROUND_ROBIN_EN
        firstIsData = 1'b0;
        sbq.push_back('{isData: 1'b0, data: pat(16)});
        sbq.push_back('{isData: 1'b1, data: 32'h5});
`else
        firstIsData = 1'b1;
        sbq.push_back('{isData: 1'b1, data: 32'h5});
        sbq.push_back('{isData: 1'b0, data: pat(16)});
`endif
        ifReq = 1'b1; ifAddr = 32'h10;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h0B;
        #1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) tick();
            chk("t3FirstAck", {63'b0, firstIsData ? dAck : ifAck}, {63'b0, c == 2});
            chk("t3SecondAck", {63'b0, firstIsData ? ifAck : dAck}, {63'b0, c == 5});
            if (c <= 4) chk("t3SecondStall", {63'b0, firstIsData ? ifStall : dStall}, 64'd1);
            if (c == 2) begin
                if (firstIsData) dReq = 1'b0; else ifReq = 1'b0;
            end
            if (c == 5) begin
                ifReq = 1'b0; dReq = 1'b0;
            end
        end
        tick();

        // Both held for four grants from a fresh reset.
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        chk("t4RstDRdata", {32'b0, dRdata}, 64'd0);
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        sbq.push_back('{isData: 1'b1, data: pat(32)});
        sbq.push_back('{isData: 1'b0, data: pat(33)});
        sbq.push_back('{isData: 1'b1, data: pat(32)});
        sbq.push_back('{isData: 1'b0, data: pat(33)});
`else
        for (int g = 0; g < 4; g++) sbq.push_back('{isData: 1'b1, data: pat(32)});
`endif
        ifReq = 1'b1; ifAddr = 32'h21;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h20;
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk("t4AckSlot", {63'b0, ifAck | dAck}, {63'b0, (c % 3) == 2});
        end
        ifReq = 1'b0; dReq = 1'b0;
        tick();
        chk("t4Idle", {63'b0, busy}, 64'd0);
        tick();

        // Reset in the middle of a slow fetch.
        memLat = 10;
        ifReq = 1'b1; ifAddr = 32'h30;
        tick();
        tick();
        chk("t5BusyBefore", {63'b0, memReq}, 64'd1);
        resetN = 1'b0;
        #1;
        chk("t5MemReqAsync", {63'b0, memReq}, 64'd0);
        chk("t5BusyAsync", {63'b0, busy}, 64'd0);
        chk("t5NoAck", {62'b0, ifAck, dAck}, 64'd0);
        ifReq = 1'b0;
        tick();
        resetN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5Quiet", {62'b0, ifAck, dAck}, 64'd0);
        end
        memLat = 1;
        ifReq = 1'b1; ifAddr = 32'h31;
        sbq.push_back('{isData: 1'b0, data: pat(49)});
        tick();
        chk("t5RetryReq", {63'b0, memReq}, 64'd1);
        tick();
        chk("t5RetryAck", {63'b0, ifAck}, 64'd1);
        ifReq = 1'b0;
        tick();

        // Data read dropped mid-access still completes.
        memLat = 3;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h40;
        sbq.push_back('{isData: 1'b1, data: pat(64)});
        tick();
        tick();
        dReq = 1'b0;
        #1;
        chk("t6StallDropped", {63'b0, dStall}, 64'd0);
        chk("t6StillBusy", {63'b0, memReq}, 64'd1);
        tick();
        chk("t6NoAckYet", {63'b0, dAck}, 64'd0);
        tick();
        chk("t6DAck", {63'b0, dAck}, 64'd1);
        tick();
        chk("t6Idle", {63'b0, busy}, 64'd0);
        chk("t6AckGone", {63'b0, dAck}, 64'd0);

        tick();
        tick();
        chk("sbEmpty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported backing memory between the instruction-fetch port (PC/instruction-memory side) and the data-access port (ALU_MEM/data-memory side) of the five-stage pipeline. It serialises accesses and drives the memory handshake. It returns read data with a one-cycle acknowledge per request, and generates per-port stall signals that freeze the PC/IF_ID and the ALU_MEM stages while their access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width of both ports and memory side
- DATA_W, 32, data width

Ports (name direction width meaning):
- clk  in  1  clock; all state on rising edge
- resetN  in  1  reset, asynchronous, active-low
- ifReq  in  1  fetch request; held with ifAddr stable until ifAck
- ifAddr  in  ADDR_W  fetch address
- ifAck  out  1  one-cycle pulse; ifRdata valid this cycle
- ifRdata  out  DATA_W  fetched instruction, registered
- ifStall  out  1  ifReq & ~ifAck
- dReq  in  1  data request; held with dWe/dAddr/dWdata stable until dAck
- dWe  in  1  1 = write, 0 = read
- dAddr  in  ADDR_W  data address
- dWdata  in  DATA_W  write data
- dAck  out  1  one-cycle pulse; dRdata valid this cycle (reads)
- dRdata  out  DATA_W  read data, registered
- dStall  out  1  dReq & ~dAck
- memReq  out  1  memory access in progress, registered
- memWe  out  1  write strobe, registered
- memAddr  out  ADDR_W  registered address
- memWdata  out  DATA_W  registered write data
- memReady  in  1  memory completes current access this cycle
- memRdata  in  DATA_W  read data, valid with memReady
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: when any request is pending, choose a winner. Latch addr/we/wdata into mem* and latch the owner. Go to BUSY. With no request, stay in IDLE.
- Winner selection without the macro: fixed priority. Data beats fetch.
- BUSY: memReq=1. mem* is held constant. On memReady=1, capture memRdata into the owner's rdata register and go to RESP.
- RESP: pulse the owner's ack for exactly 1 cycle. memReq=0. Return to IDLE. A held request is never re-granted in RESP, because the requester removes or changes it after ack.
- The other port's rdata register keeps its old value.
- The fetch port is read-only. memWe is 0 on every fetch grant.
- Requester drops req during BUSY (protocol violation): the access still completes and ack still pulses. Writes are still performed.
- Both ports are never acked in the same cycle.

## Timing
- Reset, asynchronous, effective immediately:
  - state=IDLE, memReq=0, memWe=0
  - memAddr=0, memWdata=0
  - ifAck=dAck=0, ifRdata=dRdata=0
  - busy=0, owner=none, last-grant=fetch
- Request seen in IDLE at edge 0 → memReq=1 in cycle 1.
- memReady in cycle k (k≥1) → ack in cycle k+1 → IDLE in cycle k+2.
- Minimum request-to-ack is 2 cycles. Throughput is one access per 3 cycles when memReady returns immediately.
- Stalls are combinational from req and ack. Stall is 0 in the ack cycle, so the pipeline advances on that edge.
- A request arriving while BUSY/RESP waits. It is granted from IDLE at the earliest.
- resetN asserted mid-BUSY: the access is abandoned, memReq drops asynchronously, and no ack is issued.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both ports request in IDLE, the port not granted last wins.
  - Last-grant updates on every grant.
  - Last-grant resets to fetch, so the first contended grant goes to data.
- ARB_ROUND_ROBIN_EN undefined: fixed data-over-fetch priority. The last-grant register is not built.

## Structure
- Shared package holds:
  - state encoding (IDLE/BUSY/RESP)
  - owner encoding (NONE/IF/DATA)
  - default ADDR_W/DATA_W constants
- One sub-module, arb_pick: combinational winner selection from ifReq, dReq and last-grant. It contains the ARB_ROUND_ROBIN_EN variant.
- The FSM, mem* registers and rdata registers stay in mem_port_arbiter.

## Test plan
- Fetch read only: ifReq, ifAddr=0x06, memReady in cycle 1 with memRdata=0x00A00093.
  - Expect ifAck in cycle 2 and ifRdata=0x00A00093.
  - Expect ifStall high in cycles 0–1.
- Data write, memory latency 3: dReq, dWe=1, dAddr=0x0B, dWdata=0x5.
  - Expect memWe=1, memAddr=0x0B held for cycles 1–3.
  - Expect dAck in cycle 4.
  - Expect dRdata unchanged.
- Simultaneous ifReq and dReq, fixed priority, memReady immediate.
  - Expect data acked in cycle 2 and fetch acked in cycle 5.
  - Expect ifStall high throughout cycles 0–4.
- Same stimulus with ARB_ROUND_ROBIN_EN, both held continuously for 4 grants.
  - Expect grant order data, fetch, data, fetch.
- resetN pulsed low in cycle 2 of a BUSY access.
  - Expect memReq=0 immediately, no ack, state IDLE.
  - After release, a new ifReq completes normally.
- dReq dropped in cycle 2 of BUSY.
  - Expect the access to complete, dAck pulse in the cycle after memReady, then return to IDLE.
